devolucion_cambio: RTL and testbench
====================================

# devolucion_cambio

Change-return dispenser for the vending machine. The credit/selection logic computes the refund, in credit units, and hands it to this block. The block pays the refund to the coin hopper one coin at a time over a req/ack handshake. It selects denominations greedily (5, 2, 1 units), tracks hopper stock per denomination, and reports completion, shortfall and hopper faults.

## Interface
Parameters:
- AMT_W, 4: width of refund amount and shortfall (max refund 2^AMT_W-1 units)
- STOCK_W, 4: width of each per-denomination stock counter
- STOCK_INIT, 8: stock loaded into each denomination counter on reset and refill
- TIMEOUT, 15: cycles to wait for coin_ack before faulting (used only with CAMBIO_TIMEOUT_EN)

Ports:
- clk, input, 1: single clock; all logic on rising edge
- reset, input, 1: synchronous, active-high
- start, input, 1: pulse; request refund of `amount`; sampled only in IDLE
- amount, input, AMT_W: refund value in credit units, captured when start is accepted
- refill, input, 1: reload all stocks to STOCK_INIT; honoured only in IDLE
- coin_ack, input, 1: hopper has ejected the requested coin
- coin_req, output, 1: coin ejection request to the hopper
- coin_sel, output, 2: denomination requested: 01 = 1 unit, 10 = 2 units, 11 = 5 units, 00 = none
- busy, output, 1: refund in progress (state is not IDLE)
- done, output, 1: one-cycle pulse when a refund ends, whether successful or failed
- error, output, 1: refund ended unpaid; held until the next accepted start, or reset
- short, output, AMT_W: unpaid remainder; valid while error is 1, 0 otherwise
- empty, output, 3: stock-zero flags per denomination [2]=5, [1]=2, [0]=1

## Operation
- States: IDLE, SELECT, REQ, DONE, ERR.
- IDLE: start=1 loads `remaining` from amount, clears error/short, and moves to SELECT. refill=1 reloads stocks. If start and refill are both high in the same cycle, both take effect.
- SELECT (1 cycle, coin_req=0) decides the next step:
  - remaining==0 goes to DONE.
  - Otherwise pick the first denomination that fits, in the order 5, 2, 1: remaining ≥ value and stock > 0. Latch it into coin_sel and go to REQ.
  - If no denomination fits, go to ERR.
- REQ: coin_req=1, with coin_sel held stable.
  - coin_ack=1 sampled: remaining −= value, that denomination's stock −= 1, back to SELECT.
  - coin_ack while not in REQ is ignored.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1, error=1, short=remaining, then IDLE. error and short stay latched afterwards.
- Arithmetic: remaining never underflows (the fit check guarantees value ≤ remaining). Stock never decrements below 0.
- start outside IDLE and refill outside IDLE are ignored.
- Greedy selection is the defined behaviour. It may fail even when a non-greedy payout exists (e.g. 6 units with no 1-unit coins: 5 is paid, short=1).
- Reset values: coin_req=0, coin_sel=00, busy=0, done=0, error=0, short=0, remaining=0, all stocks=STOCK_INIT, empty=000.
- Reset mid-refund aborts immediately. No done pulse is produced and stocks are reloaded.

## Timing
- start sampled at edge N: SELECT during cycle N+1, coin_req=1 from cycle N+2.
- Ack sampled at edge M: coin_req=0 in cycle M+1 (SELECT). The next coin_req rises in cycle M+2. This gives a guaranteed ≥1 low cycle between coins.
- Per coin: 2 cycles plus hopper ack latency.
- amount=0: done in cycle N+2, with no coin_req.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- CAMBIO_TIMEOUT_EN defined:
  - A counter runs while in REQ and clears on entry to REQ.
  - If TIMEOUT cycles elapse without coin_ack, go to ERR with short=remaining. The stock for that coin is not decremented.
  - coin_req drops the cycle after the timeout.
- Not defined: REQ waits indefinitely, there is no counter, and error is raised only by the stock shortfall path.

## Test plan
- Default params, amount=8, ack 1 cycle after each req: coin_sel sequence 11, 10, 01. done pulses with error=0; stocks become 7/7/7.
- amount=0: done pulses 2 cycles after start, coin_req never high, busy=1 for exactly 2 cycles.
- STOCK_INIT=1, amount=12: coins paid 5, 2, 1, then ERR. Result: done=1, error=1, short=4, empty=111.
- CAMBIO_TIMEOUT_EN, amount=3, coin_ack held 0: coin_req is high for 15 cycles, then ERR with short=3, stocks unchanged. Without the macro, coin_req stays high for 100+ cycles.
- Second start pulse while busy and refill while busy: both ignored, and the first refund completes unchanged. Then refill in IDLE restores empty=000.
- reset asserted while coin_req=1: the next cycle has coin_req=0, busy=0, done=0, and stocks=STOCK_INIT.

Source files
------------

// File: rtl/devolucion_cambio_if.sv
// rtl/devolucion_cambio_if.sv - refund request and coin hopper handshake bundle
interface devolucion_cambio_if #(
    parameter int AMT_W = 4
);
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             refill;
    logic             coin_ack;
    logic             coin_req;
    logic [1:0]       coin_sel;
    logic             busy;
    logic             done;
    logic             error;
    logic [AMT_W-1:0] short;
    logic [2:0]       empty;

    modport master (
        output start, amount, refill, coin_ack,
        input  coin_req, coin_sel, busy, done, error, short, empty
    );

    modport slave (
        input  start, amount, refill, coin_ack,
        output coin_req, coin_sel, busy, done, error, short, empty
    );
endinterface

// File: rtl/devolucion_cambio.sv
// rtl/devolucion_cambio.sv - greedy 5/2/1 change dispenser with per-denomination stock
// Optional hopper-ack timeout enabled by defining CAMBIO_TIMEOUT_EN.
module devolucion_cambio #(
    parameter int AMT_W      = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                i_clk,
    input  logic                i_reset,
    devolucion_cambio_if.slave  io_bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_REQ    = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [STOCK_W-1:0] LP_INIT = STOCK_W'(STOCK_INIT);

    state_t             r_state, w_state_nxt;
    logic [AMT_W-1:0]   r_remaining, w_remaining_nxt;
    logic [1:0]         r_coin_sel, w_coin_sel_nxt;
    logic [STOCK_W-1:0] r_stock [3];
    logic [STOCK_W-1:0] w_stock_nxt [3];
    logic               r_error, w_error_nxt;
    logic [AMT_W-1:0]   r_short, w_short_nxt;
    logic               r_coin_req;
    logic               r_busy;
    logic               r_done;
    logic [2:0]         r_empty;
    logic [AMT_W-1:0]   w_coin_val;
    logic [1:0]         w_coin_idx;
    logic               w_tmo_hit;

`ifdef CAMBIO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo_cnt;

    // Counter is held at zero outside REQ, so every new coin request starts fresh.
    always_ff @(posedge i_clk) begin
        if (i_reset || r_state != S_REQ) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    assign w_tmo_hit = (r_state == S_REQ) && (r_tmo_cnt == TW'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_tmo_hit        = 1'b0;
`endif

    // Stock index 0/1/2 holds the 1/2/5-unit coins, matching coin_sel 01/10/11.
    always_comb begin
        w_coin_val = AMT_W'(1);
        w_coin_idx = 2'd0;
        case (r_coin_sel)
            2'b11: begin w_coin_val = AMT_W'(5); w_coin_idx = 2'd2; end
            2'b10: begin w_coin_val = AMT_W'(2); w_coin_idx = 2'd1; end
            default: begin w_coin_val = AMT_W'(1); w_coin_idx = 2'd0; end
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_coin_sel_nxt  = r_coin_sel;
        w_stock_nxt     = r_stock;
        w_error_nxt     = r_error;
        w_short_nxt     = r_short;

        case (r_state)
            S_IDLE: begin
                if (io_bus.refill) begin
                    for (int i = 0; i < 3; i++) w_stock_nxt[i] = LP_INIT;
                end
                if (io_bus.start) begin
                    w_remaining_nxt = io_bus.amount;
                    w_error_nxt     = 1'b0;
                    w_short_nxt     = '0;
                    w_state_nxt     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_remaining == '0) begin
                    w_coin_sel_nxt = 2'b00;
                    w_state_nxt    = S_DONE;
                end else if (r_remaining >= AMT_W'(5) && r_stock[2] != '0) begin
                    w_coin_sel_nxt = 2'b11;
                    w_state_nxt    = S_REQ;
                end else if (r_remaining >= AMT_W'(2) && r_stock[1] != '0) begin
                    w_coin_sel_nxt = 2'b10;
                    w_state_nxt    = S_REQ;
                end else if (r_stock[0] != '0) begin
                    w_coin_sel_nxt = 2'b01;
                    w_state_nxt    = S_REQ;
                end else begin
                    w_coin_sel_nxt = 2'b00;
                    w_error_nxt    = 1'b1;
                    w_short_nxt    = r_remaining;
                    w_state_nxt    = S_ERR;
                end
            end
            S_REQ: begin
                if (io_bus.coin_ack) begin
                    w_remaining_nxt = r_remaining - w_coin_val;
                    if (r_stock[w_coin_idx] != '0) begin
                        w_stock_nxt[w_coin_idx] = r_stock[w_coin_idx] - STOCK_W'(1);
                    end
                    w_state_nxt = S_SELECT;
                end else if (w_tmo_hit) begin
                    w_coin_sel_nxt = 2'b00;
                    w_error_nxt    = 1'b1;
                    w_short_nxt    = r_remaining;
                    w_state_nxt    = S_ERR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they change with the state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_coin_sel  <= 2'b00;
            r_error     <= 1'b0;
            r_short     <= '0;
            r_coin_req  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_empty     <= 3'b000;
            for (int i = 0; i < 3; i++) r_stock[i] <= LP_INIT;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_coin_sel  <= w_coin_sel_nxt;
            r_error     <= w_error_nxt;
            r_short     <= w_short_nxt;
            r_coin_req  <= (w_state_nxt == S_REQ);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE) || (w_state_nxt == S_ERR);
            for (int i = 0; i < 3; i++) begin
                r_stock[i] <= w_stock_nxt[i];
                r_empty[i] <= (w_stock_nxt[i] == '0);
            end
        end
    end

    assign io_bus.coin_req = r_coin_req;
    assign io_bus.coin_sel = r_coin_sel;
    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.error    = r_error;
    assign io_bus.short    = r_short;
    assign io_bus.empty    = r_empty;
endmodule

// File: tb/tb_devolucion_cambio.sv
// tb/tb_devolucion_cambio.sv - randomized refund bench against a greedy payout model
module tb_devolucion_cambio;
    localparam int AMT_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    devolucion_cambio_if #(.AMT_W(AMT_W)) bus ();

    devolucion_cambio #(
        .AMT_W(AMT_W), .STOCK_W(4), .STOCK_INIT(8), .TIMEOUT(15)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .io_bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int m_stock [3];
    int denom_val [3] = '{1, 2, 5};
    logic [1:0] exp_sel [$];
    int last_done_cyc;

    function automatic logic [2:0] m_empty();
        return {m_stock[2] == 0, m_stock[1] == 0, m_stock[0] == 0};
    endfunction

    task automatic model_payout(input int amt, output int short_o);
        int rem;
        bit found;
        rem = amt;
        exp_sel.delete();
        while (rem > 0) begin
            found = 1'b0;
            for (int d = 2; d >= 0 && !found; d--) begin
                if (rem >= denom_val[d] && m_stock[d] > 0) begin
                    rem -= denom_val[d];
                    m_stock[d]--;
                    exp_sel.push_back(2'(d + 1));
                    found = 1'b1;
                end
            end
            if (!found) break;
        end
        short_o = rem;
    endtask

    task automatic clear_inputs();
        bus.start    = 1'b0;
        bus.amount   = '0;
        bus.refill   = 1'b0;
        bus.coin_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_stock = '{8, 8, 8};
    endtask

    task automatic run_refund(input int amt, input int lat_min, input int lat_max,
                              input bit do_refill, input bit inject);
        int exp_short, lat, wait_cnt;
        bit got_done;
        logic [1:0] cur;
        if (do_refill) m_stock = '{8, 8, 8};
        model_payout(amt, exp_short);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.amount = AMT_W'(amt);
        bus.refill = do_refill;
        @(negedge clk);
        clear_inputs();
        tests_run++;
        if (bus.busy !== 1'b1 || bus.coin_req !== 1'b0 || bus.done !== 1'b0 ||
            bus.error !== 1'b0 || bus.short !== '0) begin
            tests_failed++;
            $display("FAIL select_cycle amt=%0d busy=%b req=%b done=%b err=%b short=%0d expected 1 0 0 0 0",
                     amt, bus.busy, bus.coin_req, bus.done, bus.error, bus.short);
        end
        got_done = 1'b0;
        wait_cnt = 0;
        cur = 2'b00;
        lat = $urandom_range(lat_max, lat_min);
        last_done_cyc = -1;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            @(negedge clk);
            clear_inputs();
            if (inject && cyc == 2) begin
                bus.start  = 1'b1;
                bus.amount = AMT_W'(15);
                bus.refill = 1'b1;
            end
            if (cyc == 0) begin
                tests_run++;
                if (bus.coin_req !== (exp_sel.size() > 0)) begin
                    tests_failed++;
                    $display("FAIL first_req_timing amt=%0d coin_req=%b expected %b",
                             amt, bus.coin_req, exp_sel.size() > 0);
                end
            end
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                last_done_cyc = cyc;
            end else if (bus.coin_req === 1'b1) begin
                tests_run++;
                if (wait_cnt == 0) begin
                    if (exp_sel.size() == 0) begin
                        tests_failed++;
                        $display("FAIL extra_coin amt=%0d coin_sel=%b expected no request", amt, bus.coin_sel);
                    end else begin
                        cur = exp_sel.pop_front();
                        if (bus.coin_sel !== cur) begin
                            tests_failed++;
                            $display("FAIL coin_sel amt=%0d got %b expected %b", amt, bus.coin_sel, cur);
                        end
                    end
                end else if (bus.coin_sel !== cur) begin
                    tests_failed++;
                    $display("FAIL coin_sel_stable amt=%0d got %b expected %b", amt, bus.coin_sel, cur);
                end
                if (wait_cnt >= lat) begin
                    bus.coin_ack = 1'b1;
                    wait_cnt = 0;
                    lat = $urandom_range(lat_max, lat_min);
                end else begin
                    wait_cnt++;
                end
            end
        end
        clear_inputs();
        tests_run++;
        if (!got_done) begin
            tests_failed++;
            $display("FAIL done_timeout amt=%0d no done pulse within 400 cycles", amt);
        end else begin
            if (bus.error !== (exp_short != 0) || bus.short !== AMT_W'(exp_short) || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL result amt=%0d err=%b short=%0d busy=%b expected err=%b short=%0d busy=1",
                         amt, bus.error, bus.short, bus.busy, exp_short != 0, exp_short);
            end
            tests_run++;
            if (bus.empty !== m_empty() || exp_sel.size() != 0) begin
                tests_failed++;
                $display("FAIL empty_or_missing amt=%0d empty=%b expected %b coins_left=%0d expected 0",
                         amt, bus.empty, m_empty(), exp_sel.size());
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse_width amt=%0d done=%b busy=%b expected 0 0", amt, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.coin_req !== 1'b0 || bus.coin_sel !== 2'b00 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl req=%b sel=%b busy=%b expected 0 00 0", bus.coin_req, bus.coin_sel, bus.busy);
        end
        tests_run++;
        if (bus.done !== 1'b0 || bus.error !== 1'b0 || bus.short !== '0 || bus.empty !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_status done=%b err=%b short=%0d empty=%b expected 0 0 0 000",
                     bus.done, bus.error, bus.short, bus.empty);
        end
    endtask

    task automatic test_amount_zero();
        run_refund(0, 0, 0, 1'b0, 1'b0);
        tests_run++;
        if (last_done_cyc != 0) begin
            tests_failed++;
            $display("FAIL zero_done_latency done at loop cycle %0d expected 0 (two cycles after start)", last_done_cyc);
        end
    endtask

    task automatic test_basic_8();
        run_refund(8, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_short_stock();
        int seq [6] = '{15, 15, 10, 12, 12, 7};
        for (int i = 0; i < 6; i++) run_refund(seq[i], 0, 2, (i == 0), 1'b0);
    endtask

    task automatic test_refill_idle();
        @(negedge clk);
        bus.refill = 1'b1;
        @(negedge clk);
        bus.refill = 1'b0;
        m_stock = '{8, 8, 8};
        tests_run++;
        if (bus.empty !== 3'b000 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL refill_idle empty=%b busy=%b expected 000 0", bus.empty, bus.busy);
        end
    endtask

    task automatic test_ignore_busy();
        run_refund(7, 1, 2, 1'b0, 1'b1);
        run_refund(9, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_refund(15, 0, 0, 1'b1, 1'b0);
        run_refund(15, 0, 0, 1'b0, 1'b0);
        run_refund(10, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.amount = AMT_W'(3);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.coin_req !== 1'b1 || bus.empty !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_mid_setup req=%b empty=%b expected 1 100", bus.coin_req, bus.empty);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.coin_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.empty !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_mid req=%b busy=%b done=%b empty=%b expected 0 0 0 000",
                     bus.coin_req, bus.busy, bus.done, bus.empty);
        end
        reset = 1'b0;
        m_stock = '{8, 8, 8};
    endtask

    task automatic test_no_ack();
        int n;
        m_stock = '{8, 8, 8};
        @(negedge clk);
        bus.start  = 1'b1;
        bus.amount = AMT_W'(3);
        bus.refill = 1'b1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.coin_req !== 1'b1 || bus.coin_sel !== 2'b10) begin
            tests_failed++;
            $display("FAIL no_ack_first_req req=%b sel=%b expected 1 10", bus.coin_req, bus.coin_sel);
        end
        n = 0;
`ifdef CAMBIO_TIMEOUT_EN
        while (bus.coin_req === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 15) begin
            tests_failed++;
            $display("FAIL timeout_req_cycles coin_req high %0d cycles expected 15", n);
        end
        tests_run++;
        if (bus.done !== 1'b1 || bus.error !== 1'b1 || bus.short !== AMT_W'(3) || bus.empty !== 3'b000) begin
            tests_failed++;
            $display("FAIL timeout_err done=%b err=%b short=%0d empty=%b expected 1 1 3 000",
                     bus.done, bus.error, bus.short, bus.empty);
        end
        run_refund(3, 0, 0, 1'b0, 1'b0);
`else
        while (bus.coin_req === 1'b1 && n < 120) begin
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 120 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_timeout_hold coin_req high %0d cycles done=%b expected 120 0", n, bus.done);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_stock = '{8, 8, 8};
        tests_run++;
        if (bus.coin_req !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_ack_abort req=%b busy=%b expected 0 0", bus.coin_req, bus.busy);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_refund($urandom_range(15, 0), 0, 3, ($urandom_range(3, 0) == 0), 1'b0);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        m_stock = '{8, 8, 8};
        test_reset();
        test_amount_zero();
        test_basic_8();
        test_short_stock();
        test_refill_idle();
        test_ignore_busy();
        test_reset_mid();
        test_no_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
